// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
// Used by hazard_ctrl and its perf-counter option (HAZARD_PERF_CNT_EN).
package hazard_pkg;

    typedef enum logic [0:0] {
        HZ_RUN,
        HZ_DRAIN
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_RUN = '{
        pc_we:       1'b1,
        if_id_we:    1'b1,
        id_ex_we:    1'b1,
        ex_mem_we:   1'b1,
        mem_wb_we:   1'b1,
        if_id_flush: 1'b0,
        id_ex_flush: 1'b0
    };

    localparam hz_ctl_t CTL_FREEZE = '{
        pc_we:       1'b0,
        if_id_we:    1'b0,
        id_ex_we:    1'b0,
        ex_mem_we:   1'b0,
        mem_wb_we:   1'b0,
        if_id_flush: 1'b0,
        id_ex_flush: 1'b0
    };

    localparam hz_ctl_t CTL_RST = '{
        pc_we:       1'b0,
        if_id_we:    1'b0,
        id_ex_we:    1'b0,
        ex_mem_we:   1'b0,
        mem_wb_we:   1'b0,
        if_id_flush: 1'b1,
        id_ex_flush: 1'b1
    };

    function automatic logic load_use_hit(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2,
        input logic [4:0] rd,
        input logic       mem_read
    );
        logic m1;
        logic m2;
        m1 = use_rs1 && (rd == rs1);
        m2 = use_rs2 && (rd == rs2);
        return mem_read && (rd != REG_ZERO) && (m1 || m2);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline (load-use, IM/DM wait, redirect).
// Define HAZARD_PERF_CNT_EN to add saturating perf counters (cnt_* ports).
module hazard_ctrl
    import hazard_pkg::*;
`ifdef HAZARD_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_use_rs1,
    input  logic       ID_use_rs2,
    input  logic [4:0] EX_rd,
    input  logic       EX_MemRead,
    input  logic       branch_taken,
    input  logic       IM_stall,
    input  logic       DM_stall,
    output logic       pc_we,
    output logic       if_id_we,
    output logic       id_ex_we,
    output logic       ex_mem_we,
    output logic       mem_wb_we,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       drain
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_load_use,
    output logic [CNT_W-1:0] cnt_mem_stall,
    output logic [CNT_W-1:0] cnt_redirect
`endif
);

    hz_state_e state_d;
    hz_state_e state_q;
    hz_ctl_t   ctl;

    logic hit;
    logic redir_now;
    logic redir_wait;
    logic fetch_wait;
    logic lu_stall;

    // Mutually exclusive RUN conditions, highest priority first.
    assign hit = load_use_hit(ID_rs1, ID_rs2, ID_use_rs1,
                              ID_use_rs2, EX_rd, EX_MemRead);
    assign redir_now  = !DM_stall &&  branch_taken && !IM_stall;
    assign redir_wait = !DM_stall &&  branch_taken &&  IM_stall;
    assign fetch_wait = !DM_stall && !branch_taken &&  IM_stall;
    assign lu_stall   = !DM_stall && !branch_taken && !IM_stall && hit;

    always_comb begin
        state_d = state_q;
        ctl     = CTL_RUN;
        unique case (state_q)
            HZ_RUN: begin
                unique case (1'b1)
                    DM_stall: begin
                        ctl = CTL_FREEZE;
                    end
                    redir_now: begin
                        ctl.if_id_flush = 1'b1;
                        ctl.id_ex_flush = 1'b1;
                    end
                    redir_wait: begin
                        ctl.if_id_we    = 1'b0;
                        ctl.id_ex_flush = 1'b1;
                        state_d         = HZ_DRAIN;
                    end
                    fetch_wait, lu_stall: begin
                        ctl.pc_we       = 1'b0;
                        ctl.if_id_we    = 1'b0;
                        ctl.id_ex_flush = 1'b1;
                    end
                    default: ;
                endcase
            end
            HZ_DRAIN: begin
                // EX only holds bubbles here, so older stages drain freely.
                ctl.pc_we       = 1'b0;
                ctl.if_id_we    = 1'b0;
                ctl.id_ex_we    = !DM_stall;
                ctl.ex_mem_we   = !DM_stall;
                ctl.mem_wb_we   = !DM_stall;
                ctl.id_ex_flush = 1'b1;
                if (!IM_stall) begin
                    ctl.if_id_flush = 1'b1;
                    state_d         = HZ_RUN;
                end
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
        if (!rst_n) begin
            ctl = CTL_RST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_we       = ctl.pc_we;
    assign if_id_we    = ctl.if_id_we;
    assign id_ex_we    = ctl.id_ex_we;
    assign ex_mem_we   = ctl.ex_mem_we;
    assign mem_wb_we   = ctl.mem_wb_we;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_flush = ctl.id_ex_flush;
    assign drain       = (state_q == HZ_DRAIN);

`ifdef HAZARD_PERF_CNT_EN
    logic run;
    logic ev_load_use;
    logic ev_mem_stall;
    logic ev_redirect;

    assign run          = (state_q == HZ_RUN);
    assign ev_load_use  = run && lu_stall;
    assign ev_mem_stall = IM_stall || DM_stall;
    assign ev_redirect  = run && (redir_now || redir_wait);

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_load_use (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_load_use),
        .cnt   (cnt_load_use)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_mem_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_mem_stall),
        .cnt   (cnt_mem_stall)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_redirect (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_redirect),
        .cnt   (cnt_redirect)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic
// against a rule-level reference model (counters checked when HAZARD_PERF_CNT_EN).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] ID_rs1 = '0;
    logic [4:0] ID_rs2 = '0;
    logic       ID_use_rs1 = 1'b0;
    logic       ID_use_rs2 = 1'b0;
    logic [4:0] EX_rd = '0;
    logic       EX_MemRead = 1'b0;
    logic       branch_taken = 1'b0;
    logic       IM_stall = 1'b0;
    logic       DM_stall = 1'b0;
    logic       pc_we;
    logic       if_id_we;
    logic       id_ex_we;
    logic       ex_mem_we;
    logic       mem_wb_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       drain;

    int checks = 0;
    int failures = 0;
    bit m_drain = 1'b0;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt_load_use;
    logic [31:0] cnt_mem_stall;
    logic [31:0] cnt_redirect;
    logic [31:0] m_lu = '0;
    logic [31:0] m_ms = '0;
    logic [31:0] m_rd = '0;
    logic        sat_inc = 1'b0;
    logic [2:0]  sat_cnt;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rd(EX_rd), .EX_MemRead(EX_MemRead),
        .branch_taken(branch_taken),
        .IM_stall(IM_stall), .DM_stall(DM_stall),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .drain(drain),
        .cnt_load_use(cnt_load_use),
        .cnt_mem_stall(cnt_mem_stall),
        .cnt_redirect(cnt_redirect)
    );

    hazard_perf_cnt #(.CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .inc(sat_inc), .cnt(sat_cnt)
    );
`else
    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rd(EX_rd), .EX_MemRead(EX_MemRead),
        .branch_taken(branch_taken),
        .IM_stall(IM_stall), .DM_stall(DM_stall),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .drain(drain)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {pc,if_id,id_ex,ex_mem,mem_wb we, if_id_flush, id_ex_flush}.
    function automatic logic [6:0] exp_ctl(input bit dr, input bit rn,
                                           input bit lu, input bit br,
                                           input bit im, input bit dm);
        if (!rn) return 7'b00000_11;
        if (dr)  return {1'b0, 1'b0, !dm, !dm, !dm, !im, 1'b1};
        if (dm)  return 7'b00000_00;
        if (br)  return {1'b1, !im, 1'b1, 1'b1, 1'b1, !im, 1'b1};
        if (im || lu) return 7'b00111_01;
        return 7'b11111_00;
    endfunction

    task automatic step(input string tag, input bit rn,
                        input int rs1, input int rs2,
                        input bit u1, input bit u2,
                        input int rd, input bit mr,
                        input bit br, input bit im, input bit dm);
        logic [6:0] e;
        logic [6:0] o;
        bit lu;
        @(negedge clk);
        rst_n = rn;
        ID_rs1 = 5'(rs1);
        ID_rs2 = 5'(rs2);
        ID_use_rs1 = u1;
        ID_use_rs2 = u2;
        EX_rd = 5'(rd);
        EX_MemRead = mr;
        branch_taken = br;
        IM_stall = im;
        DM_stall = dm;
        #1;
        lu = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        if (!rn) begin
            m_drain = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
            m_lu = '0;
            m_ms = '0;
            m_rd = '0;
`endif
        end
        e = exp_ctl(m_drain, rn, lu, br, im, dm);
        o = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
             if_id_flush, id_ex_flush};
        // id_ex_we is a don't-care while draining (flush forces a bubble).
        if (m_drain) begin
            o[4] = 1'b0;
            e[4] = 1'b0;
        end
        chk({tag, "/ctl"}, 32'(o), 32'(e));
        chk({tag, "/drain"}, 32'(drain), 32'(m_drain));
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "/cnt_lu"}, cnt_load_use, m_lu);
        chk({tag, "/cnt_ms"}, cnt_mem_stall, m_ms);
        chk({tag, "/cnt_rd"}, cnt_redirect, m_rd);
        if (rn) begin
            if (!m_drain && !dm && !br && !im && lu) m_lu = m_lu + 1;
            if (im || dm) m_ms = m_ms + 1;
            if (!m_drain && !dm && br) m_rd = m_rd + 1;
        end
`endif
        if (rn) begin
            if (m_drain) m_drain = im;
            else m_drain = !dm && br && im;
        end
    endtask

    initial begin
        // reset and idle
        step("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_hold", 0, 3, 3, 1, 1, 3, 1, 1, 1, 0);
        step("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        step("lu_rs1", 1, 5, 1, 1, 1, 5, 1, 0, 0, 0);
        step("lu_after", 1, 5, 1, 1, 1, 0, 0, 0, 0, 0);
        step("lu_rs2", 1, 1, 5, 1, 1, 5, 1, 0, 0, 0);
        step("lu_nouse", 1, 5, 1, 0, 1, 5, 1, 0, 0, 0);
        step("lu_x0", 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        step("lu_nomr", 1, 5, 5, 1, 1, 5, 0, 0, 0, 0);

        // DM wait dominates load-use and branch
        for (int i = 0; i < 4; i++)
            step("dm_freeze", 1, 5, 5, 1, 1, 5, 1, 1, 0, 1);
        step("dm_release", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // redirect with fetch done
        step("br", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("br_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // redirect while fetch outstanding, then drain
        step("br_im", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++)
            step("drain_im", 1, 5, 5, 1, 1, 5, 1, 1, 1, 0);
        step("drain_ret_dm", 1, 5, 5, 1, 1, 5, 1, 1, 0, 1);
        step("run_again", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // async reset mid-drain
        step("br_im2", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("drain_im2", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("post_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("post_rst2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 $urandom_range(0, 59) != 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 int'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0);
        end

`ifdef HAZARD_PERF_CNT_EN
        // saturation on a narrow counter
        @(negedge clk);
        sat_inc = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("sat_max", 32'(sat_cnt), 32'd7);
        @(negedge clk);
        chk("sat_hold", 32'(sat_cnt), 32'd7);
        sat_inc = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("sat_rst", 32'(sat_cnt), 32'd0);
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
